// File: rtl/luhn_pkg.sv
// Shared types and helpers for the card-number entry / Luhn check block.
// Holds the FSM state enum, default capacity, key polarity and one-hot decode.
package luhn_pkg;

   typedef enum logic [1:0] {
      ENTRY,
      CHECK,
      DONE
   } state_t;

   localparam int DEF_MAX_DIGITS = 16;

   // Converter keys are active-low levels
   localparam logic KEY_ON  = 1'b0;
   localparam logic KEY_OFF = 1'b1;

   // Returns {valid, bcd}; valid only when exactly one bit is set
   function automatic logic [4:0] onehot_to_bcd(input logic [9:0] oh);
      logic [3:0] bcd;
      int unsigned n;
      bcd = '0;
      n   = 0;
      for (int k = 0; k < 10; k++) begin
         if (oh[k]) begin
            n++;
            bcd = 4'(k);
         end
      end
      return {(n == 1), bcd};
   endfunction

endpackage

// File: rtl/luhn_step.sv
// One Luhn accumulation step: acc_next = (acc + term(d, odd)) mod 10.
// Ports: d, odd (doubling position), acc in; acc_next out. Purely combinational.
module luhn_step (
   input  logic [3:0] d,
   input  logic       odd,
   input  logic [3:0] acc,
   output logic [3:0] acc_next
);

   logic [4:0] dbl;
   logic [4:0] term;
   logic [4:0] sum;

   always_comb begin
      dbl  = {d, 1'b0};
      term = {1'b0, d};
      if (odd) begin
         // Doubled digit folded back to its digit sum
         term = (dbl > 5'd9) ? dbl - 5'd9 : dbl;
      end
      sum      = {1'b0, acc} + term;
      acc_next = (sum >= 5'd10) ? 4'(sum - 5'd10) : sum[3:0];
   end

endmodule

// File: rtl/luhn_entry_controller.sv
// Card-number entry buffer with a one-digit-per-cycle Luhn checker.
// In: CLOCK_50, reset, number, shift, check_luhn, clear. Out: digits, digit_count, busy, done, luhn_valid, overflow.
module luhn_entry_controller
   import luhn_pkg::*;
#(
   parameter int MAX_DIGITS = DEF_MAX_DIGITS,
   parameter int CW         = $clog2(MAX_DIGITS + 1)
) (
   input  logic                    CLOCK_50,
   input  logic                    reset,
   input  logic [9:0]              number,
   input  logic                    shift,
   input  logic                    check_luhn,
   input  logic                    clear,
   output logic [4*MAX_DIGITS-1:0] digits,
   output logic [CW-1:0]           digit_count,
   output logic                    busy,
   output logic                    done,
   output logic                    luhn_valid,
   output logic                    overflow
);

   state_t state_q, state_n;

   logic                    shift_q, chk_q;
   logic [CW-1:0]           idx_q, idx_n;
   logic [3:0]              acc_q, acc_n;
   logic [4*MAX_DIGITS-1:0] digits_n;
   logic [CW-1:0]           count_n;
   logic                    busy_n, done_n, valid_n, ovf_n;

   logic       commit, req, full, last;
   logic [4:0] dec;
   logic [3:0] cur_d, acc_step;

   assign commit = (shift_q == KEY_OFF) && (shift == KEY_ON);
   assign req    = (chk_q == KEY_OFF) && (check_luhn == KEY_ON);
   assign dec    = onehot_to_bcd(number);
   assign full   = (digit_count == CW'(MAX_DIGITS));
   assign last   = (digit_count < CW'(2)) ||
                   (idx_q == digit_count - CW'(1));

   always_comb begin
      cur_d = '0;
      for (int k = 0; k < MAX_DIGITS; k++) begin
         if (idx_q == CW'(k)) cur_d = digits[4*k +: 4];
      end
   end

   luhn_step u_step (
      .d        (cur_d),
      .odd      (idx_q[0]),
      .acc      (acc_q),
      .acc_next (acc_step)
   );

   always_comb begin
      state_n  = state_q;
      idx_n    = idx_q;
      acc_n    = acc_q;
      digits_n = digits;
      count_n  = digit_count;
      busy_n   = busy;
      done_n   = done;
      valid_n  = luhn_valid;
      ovf_n    = overflow;

      unique case (state_q)
         ENTRY, DONE: begin
            if (clear) begin
               digits_n = '0;
               count_n  = '0;
               ovf_n    = 1'b0;
               done_n   = 1'b0;
               valid_n  = 1'b0;
               state_n  = ENTRY;
            end else begin
               if (commit && dec[4]) begin
                  if (full) begin
                     ovf_n = 1'b1;
                  end else begin
                     digits_n = {digits[4*MAX_DIGITS-5:0], dec[3:0]};
                     count_n  = digit_count + CW'(1);
                  end
                  done_n  = 1'b0;
                  valid_n = 1'b0;
                  state_n = ENTRY;
               end
               // CHECK reads the registered count, so a same-cycle commit is covered
               if (req) begin
                  idx_n   = '0;
                  acc_n   = '0;
                  busy_n  = 1'b1;
                  done_n  = 1'b0;
                  valid_n = 1'b0;
                  state_n = CHECK;
               end
            end
         end
         CHECK: begin
            acc_n = acc_step;
            idx_n = idx_q + CW'(1);
            if (last) begin
               busy_n  = 1'b0;
               done_n  = 1'b1;
               valid_n = (acc_step == 4'd0) &&
                         (digit_count >= CW'(2));
               state_n = DONE;
            end
         end
         default: state_n = ENTRY;
      endcase
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_q     <= ENTRY;
         shift_q     <= KEY_OFF;
         chk_q       <= KEY_OFF;
         idx_q       <= '0;
         acc_q       <= '0;
         digits      <= '0;
         digit_count <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         luhn_valid  <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         state_q     <= state_n;
         shift_q     <= shift;
         chk_q       <= check_luhn;
         idx_q       <= idx_n;
         acc_q       <= acc_n;
         digits      <= digits_n;
         digit_count <= count_n;
         busy        <= busy_n;
         done        <= done_n;
         luhn_valid  <= valid_n;
         overflow    <= ovf_n;
      end
   end

endmodule
